// File: rtl/simon32_64_iterative_round_core.sv
// Iterative SIMON32/64 datapath: one round per clock with an on-the-fly key schedule.
// Round 0 is applied on the load edge, so the block completes ROUNDS edges after load.
module simon32_64_iterative_round_core #(
  parameter int unsigned     ROUNDS = 32,
  parameter logic [61:0]     Z_SEQ  = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] plaintext,
  input  logic [63:0] key,
  output logic [31:0] ciphertext,
  output logic        busy,
  output logic        ct_valid,
  output logic [5:0]  round_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_t      state, state_n;
  logic [15:0] x, y, k0, k1, k2, k3;
  logic [5:0]  idx;

  logic        step;
  logic [15:0] a_in, b_in, rk;
  logic [15:0] w0, w1, w3;
  logic [5:0]  zi;
  logic [15:0] f_a, x_n, t1, t2, w4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // load always wins, which covers both abort-while-busy and reload-after-done
  always_comb begin
    state_n = state;
    if (load)
      state_n = S_RUN;
    else if (state == S_RUN && idx == LAST_IDX)
      state_n = S_DONE;
  end

  assign step = load || (state == S_RUN);

  // Load and iterate share one round/expansion unit; only the operand sources differ
  always_comb begin
    a_in = load ? plaintext[31:16] : x;
    b_in = load ? plaintext[15:0]  : y;
    rk   = load ? key[15:0]        : k0;
    w0   = load ? key[15:0]        : k0;
    w1   = load ? key[31:16]       : k1;
    w3   = load ? key[63:48]       : k3;
    zi   = load ? 6'd0             : idx;

    f_a  = ({a_in[14:0], a_in[15]} & {a_in[7:0], a_in[15:8]}) ^ {a_in[13:0], a_in[15:14]};
    x_n  = b_in ^ f_a ^ rk;

    t1   = {w3[2:0], w3[15:3]} ^ w1;
    t2   = t1 ^ {t1[0], t1[15:1]};
    w4   = ~w0 ^ t2 ^ 16'h0003 ^ {15'b0, Z_SEQ[6'd61 - zi]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x   <= '0;
      y   <= '0;
      k0  <= '0;
      k1  <= '0;
      k2  <= '0;
      k3  <= '0;
      idx <= '0;
    end else if (step) begin
      x   <= x_n;
      y   <= a_in;
      k0  <= w1;
      k1  <= load ? key[47:32] : k2;
      k2  <= w3;
      k3  <= w4;
      idx <= load ? 6'd1 : idx + 6'd1;
    end
  end

  assign ciphertext = {x, y};
  assign round_idx  = idx;
  assign busy       = (state == S_RUN);
  assign ct_valid   = (state == S_DONE);

endmodule

// File: tb/tb_simon32_64_iterative_round_core.sv
// Scoreboard bench for the iterative SIMON32/64 core: stimulus pushes expected
// ciphertexts, a negedge monitor pops one on every rising edge of ct_valid.
module tb_simon32_64_iterative_round_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] plaintext;
  logic [63:0] key;
  logic [31:0] ciphertext;
  logic        busy;
  logic        ct_valid;
  logic [5:0]  round_idx;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] exp_q[$];
  logic        prev_valid = 1'b0;

  simon32_64_iterative_round_core #(.ROUNDS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .plaintext (plaintext),
    .key       (key),
    .ciphertext(ciphertext),
    .busy      (busy),
    .ct_valid  (ct_valid),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rol16(input logic [15:0] v, input int unsigned n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] ror16(input logic [15:0] v, input int unsigned n);
    return (v >> n) | (v << (16 - n));
  endfunction

  // Software reference: full key schedule first, then 32 rounds
  function automatic logic [31:0] simon_ref(input logic [31:0] pt, input logic [63:0] k);
    string       z = "11111010001001010110000111001101111101000100101011000011100110";
    logic [15:0] ks [32];
    logic [15:0] xs, ys, tmp;
    for (int i = 0; i < 4; i++) ks[i] = k[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      tmp = ror16(ks[i-1], 3) ^ ks[i-3];
      tmp = tmp ^ ror16(tmp, 1);
      ks[i] = ~ks[i-4] ^ tmp ^ 16'h0003 ^ ((z[i-4] == "1") ? 16'h0001 : 16'h0000);
    end
    xs = pt[31:16];
    ys = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      tmp = xs;
      xs  = ys ^ (rol16(xs, 1) & rol16(xs, 8)) ^ rol16(xs, 2) ^ ks[i];
      ys  = tmp;
    end
    return {xs, ys};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for completion; returns edges taken after the current point
  task automatic wait_done(output int unsigned edges);
    edges = 0;
    while (!ct_valid && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic start_block(input logic [31:0] pt, input logic [63:0] k, input bit expect_done);
    plaintext = pt;
    key       = k;
    load      = 1'b1;
    if (expect_done) exp_q.push_back(simon_ref(pt, k));
    tick();
    load = 1'b0;
  endtask

  // Monitor: each new ct_valid must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      if (ct_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got ct %h, expected no completion", ciphertext);
        end else begin
          check("scoreboard_ct", 64'(ciphertext), 64'(exp_q.pop_front()));
        end
      end
      prev_valid = ct_valid;
    end
  end

  logic [31:0] held_ct;
  logic [31:0] vec_pt [4];
  logic [63:0] vec_key [4];
  int unsigned edges;

  initial begin
    rst       = 1'b1;
    load      = 1'b0;
    plaintext = '0;
    key       = '0;
    vec_pt[0]  = 32'h6565_6877; vec_key[0] = 64'h1918_1110_0908_0100;
    vec_pt[1]  = 32'hFFFF_FFFF; vec_key[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    vec_pt[2]  = 32'h0001_8000; vec_key[2] = 64'h0000_0000_0000_0000;
    vec_pt[3]  = 32'hA5A5_5A5A; vec_key[3] = 64'h0123_4567_89AB_CDEF;

    repeat (2) tick();
    check("reset_ct", 64'(ciphertext), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_valid", 64'(ct_valid), 64'h0);
    check("reset_idx", 64'(round_idx), 64'h0);
    rst = 1'b0;
    tick();

    // Standard vector, with the published ciphertext as a fixed expectation
    check("model_std", 64'(simon_ref(32'h6565_6877, 64'h1918_1110_0908_0100)), 64'hC69B_E9BB);
    start_block(32'h6565_6877, 64'h1918_1110_0908_0100, 1'b1);
    check("r0_ct", 64'(ciphertext), 64'hBCA2_6565);
    check("r0_idx", 64'(round_idx), 64'd1);
    check("r0_busy", 64'(busy), 64'h1);
    check("r0_valid", 64'(ct_valid), 64'h0);
    repeat (30) tick();
    check("r31_busy", 64'(busy), 64'h1);
    check("r31_idx", 64'(round_idx), 64'd31);
    check("r31_valid", 64'(ct_valid), 64'h0);
    tick();
    check("std_ct", 64'(ciphertext), 64'hC69B_E9BB);
    check("std_valid", 64'(ct_valid), 64'h1);
    check("std_busy", 64'(busy), 64'h0);
    check("std_idx", 64'(round_idx), 64'd32);

    // Idle hold
    held_ct = ciphertext;
    repeat (100) tick();
    check("hold_ct", 64'(ciphertext), 64'(held_ct));
    check("hold_valid", 64'(ct_valid), 64'h1);
    check("hold_idx", 64'(round_idx), 64'd32);

    // Back-to-back: reload while ct_valid is high
    start_block(32'h0000_0000, 64'h1918_1110_0908_0100, 1'b1);
    check("b2b_valid_drop", 64'(ct_valid), 64'h0);
    check("b2b_busy", 64'(busy), 64'h1);
    wait_done(edges);
    check("b2b_latency", 64'(edges), 64'd31);
    tick();

    // Restart at round_idx 10: block A must never complete
    start_block(32'h1234_5678, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    repeat (9) tick();
    check("restart_idx_a", 64'(round_idx), 64'd10);
    start_block(32'h89AB_CDEF, 64'h0F0E_0D0C_0B0A_0908, 1'b1);
    check("restart_idx_b", 64'(round_idx), 64'd1);
    wait_done(edges);
    check("restart_latency", 64'(edges), 64'd31);
    check("restart_ct", 64'(ciphertext), 64'(simon_ref(32'h89AB_CDEF, 64'h0F0E_0D0C_0B0A_0908)));
    tick();

    // Async reset mid-block between edges
    start_block(32'hCAFE_BABE, 64'h1111_2222_3333_4444, 1'b0);
    repeat (16) tick();
    check("rst_pre_idx", 64'(round_idx), 64'd17);
    #2 rst = 1'b1;
    #1;
    check("arst_ct", 64'(ciphertext), 64'h0);
    check("arst_flags", 64'({busy, ct_valid}), 64'h0);
    check("arst_idx", 64'(round_idx), 64'h0);
    #3 rst = 1'b0;
    repeat (5) tick();
    check("post_rst_ct", 64'(ciphertext), 64'h0);
    check("post_rst_state", 64'({busy, ct_valid, round_idx}), 64'h0);

    // Directed table through the scoreboard
    for (int v = 0; v < 4; v++) begin
      start_block(vec_pt[v], vec_key[v], 1'b1);
      wait_done(edges);
      check("table_latency", 64'(edges), 64'd31);
      tick();
    end

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/simon32_64_iterative_round_core.md
Name: simon32_64_iterative_round_core

Overview:
- Datapath consumer of the iterative SIMON controller's core interface (load, plaintext, key).
- Performs one SIMON32/64 round per clock and produces the round key on the fly with a 4-word key-schedule shift register.
- Ciphertext is held stable for the controller's ciphertext BRAM write.
- The first round is applied on the load edge, so a full encryption completes exactly 32 edges after load is sampled.

Parameters:
ROUNDS, 32, total rounds applied per block (must be ≥ 5 and ≤ 62).
Z_SEQ, 62'b11111010001001010110000111001101111101000100101011000011100110, z0 constant sequence; leftmost character = index 0.

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  one-cycle strobe: capture plaintext/key and perform round 0
plaintext  input  32  {x[31:16], y[15:0]}
key  input  64  {k3[63:48], k2[47:32], k1[31:16], k0[15:0]}
ciphertext  output  32  {x, y} state registers
busy  output  1  high while rounds 1..ROUNDS-1 remain
ct_valid  output  1  high from completion until next load
round_idx  output  6  index of the next round to apply (0..ROUNDS)

Behaviour:
- Reset (async assert, sync-free release): x, y, k0..k3 = 0; round_idx = 0; busy = 0; ct_valid = 0; ciphertext = 0.
- Round function, shared by load and iterate paths, inputs (a, b, rk):
  - f(a) = (a rotl 1 & a rotl 8) ^ (a rotl 2)
  - new x = b ^ f(a) ^ rk
  - new y = a
- Key expansion at round i, from words (w0..w3):
  - t = (w3 rotr 3) ^ w1
  - t = t ^ (t rotr 1)
  - w4 = ~w0 ^ t ^ 16'h0003 ^ {15'b0, Z_SEQ[i]}
  - Shift: w0 ← w1, w1 ← w2, w2 ← w3, w3 ← w4.
- Load edge (load = 1):
  - Apply round 0 to plaintext using key[15:0] as rk.
  - Key regs ← shifted key per expansion with i = 0.
  - round_idx ← 1; busy ← 1; ct_valid ← 0.
- Iterate edge (load = 0, busy = 1):
  - Apply round round_idx to {x, y} with rk = k0.
  - Expand key with i = round_idx.
  - round_idx ← round_idx + 1.
  - When round_idx == ROUNDS-1 on this edge: busy ← 0, ct_valid ← 1.
- Idle (load = 0, busy = 0): all registers hold.
- Latency: ciphertext is final and ct_valid = 1 after exactly ROUNDS edges counting the load edge. This matches one LOAD cycle plus 31 COUNT cycles, so ciphertext is valid in the WRITE cycle.
- load while busy: abort the current block and restart from the new inputs; load has priority.
- load in the same cycle ct_valid is high: ct_valid drops on that edge and the new block starts.
- Rounds 28..31 still expand keys; the expanded words are unused and harmless. Z_SEQ index never exceeds ROUNDS-1.
- All arithmetic is 16-bit word-wise XOR/rotate; there are no carries.
- Reset mid-block aborts immediately to the reset values; no partial result is retained.
- The ciphertext port is driven directly from registers (no combinational path from inputs).

Test Plan:
- Standard vector: key = 64'h1918_1110_0908_0100, plaintext = 32'h6565_6877, load for 1 cycle → after 32 edges ciphertext = 32'hC69B_E9BB, ct_valid = 1, busy = 0, round_idx = 32.
- Round-0 check: same vector, inspect after load edge → y = 16'h6565, round_idx = 1, busy = 1, ct_valid = 0; k0 = 16'h0908 after the shift.
- Back-to-back blocks mimicking the controller (LOAD, 31 idle-load cycles, WRITE, READ, LOAD): second plaintext 32'h0000_0000 with the same key → matches the software model; ct_valid drops on the second load edge.
- Restart: load block A, assert load with block B at round_idx = 10 → result after 32 edges from the second load equals encrypt(B); A is never flagged valid.
- Async reset: assert rst mid-block at round_idx = 17 between clock edges → all outputs 0 immediately; after release with no load, all remain 0.
- Idle hold: after completion, hold load = 0 for 100 cycles → ciphertext and ct_valid unchanged; randomized 1000-block regression against a C model gives zero mismatches.
